// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline stages: word type, fetch FSM states,
// IF/ID update selector and the skid-buffer entry layout.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_FETCH  = 2'd1,
        IFID_SKID   = 2'd2,
        IFID_BUBBLE = 2'd3
    } ifid_op_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// IF/ID pipeline register contents as seen by the fetch stage and by observers.
interface fetch_if;
    import cpu_types_pkg::*;

    word_t instr;
    word_t npc;
    word_t pc;
    logic  valid;

    modport fs (output instr, npc, pc, valid);
    modport tb (input  instr, npc, pc, valid);
endinterface

// File: rtl/fetch_skid.sv
// One-entry buffer catching an icache hit that decode cannot accept yet.
module fetch_skid
    import cpu_types_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t d,
    output fetch_entry_t q,
    output logic         full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, icache request, IF/ID register with skid buffer,
// redirect handling and halt shutdown.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall_id,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt_in,
    output word_t instr_out,
    output word_t npc_out,
    output word_t pc_out,
    output logic  valid_out,
    output logic  halted
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next, pc_plus4;
    ifid_op_t     ifid_op;
    logic         skid_load, skid_clear, skid_full;
    fetch_entry_t skid_d, skid_q;

    fetch_if ifid ();

    assign pc_plus4 = pc + 32'd4;
    assign skid_d   = '{instr: imemload, npc: pc_plus4, pc: pc};

    fetch_skid u_skid (
        .clk   (CLK),
        .rst_n (nRST),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (skid_d),
        .q     (skid_q),
        .full  (skid_full)
    );

    // Next-state, PC and IF/ID control; halt beats redirect beats normal flow.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_op    = IFID_HOLD;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (state != HALT) begin
            if (halt_in) begin
                ifid_op    = IFID_BUBBLE;
                skid_clear = 1'b1;
                state_next = HALT;
            end else if (redirect) begin
                pc_next    = {redirect_pc[31:2], 2'b00};
                ifid_op    = IFID_BUBBLE;
                skid_clear = 1'b1;
                state_next = RUN;
            end else if (state == RUN) begin
                if (ihit) begin
                    pc_next = pc_plus4;
                    if (stall_id) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_op = IFID_FETCH;
                    end
                end else if (!stall_id) begin
                    ifid_op = IFID_BUBBLE;
                end
            end else if (!stall_id) begin
                ifid_op    = IFID_SKID;
                skid_clear = 1'b1;
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            pc    <= PC_INIT;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifid.instr <= NOP_INSTR;
            ifid.npc   <= '0;
            ifid.pc    <= '0;
            ifid.valid <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_FETCH: begin
                    ifid.instr <= imemload;
                    ifid.npc   <= pc_plus4;
                    ifid.pc    <= pc;
                    ifid.valid <= 1'b1;
                end
                IFID_SKID: begin
                    ifid.instr <= skid_q.instr;
                    ifid.npc   <= skid_q.npc;
                    ifid.pc    <= skid_q.pc;
                    ifid.valid <= skid_full;
                end
                IFID_BUBBLE: begin
                    ifid.instr <= NOP_INSTR;
                    ifid.npc   <= '0;
                    ifid.pc    <= '0;
                    ifid.valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imemREN   = (state == RUN) && nRST;
    assign imemaddr  = pc;
    assign instr_out = ifid.instr;
    assign npc_out   = ifid.npc;
    assign pc_out    = ifid.pc;
    assign valid_out = ifid.valid;
    assign halted    = (state == HALT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined datapath. Holds the PC, issues instruction reads to the icache, and owns the IF/ID pipeline register whose instruction word drives the control unit's `Instr` input. Includes a one-entry skid buffer so that an icache hit is never discarded while decode is stalled. Also handles redirects from branch/jump resolution and the halt shutdown.

## Interface
- `PC_INIT`, default 32'h0000_0000, PC value loaded at reset.
- `CLK`  in  1  system clock, all state updates on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  icache hit; `imemload` is valid this cycle.
- `imemload`  in  32 (`word_t`)  instruction data from icache.
- `imemREN`  out  1  instruction read enable.
- `imemaddr`  out  32 (`word_t`)  instruction address; always equals current PC.
- `stall_id`  in  1  decode not accepting; IF/ID register must hold.
- `redirect`  in  1  taken branch/jump resolved downstream; flush and reload PC.
- `redirect_pc`  in  32 (`word_t`)  new PC; bits [1:0] ignored and stored as 00.
- `halt_in`  in  1  halt committed downstream.
- `instr_out`  out  32 (`word_t`)  IF/ID instruction (to control unit `Instr`).
- `npc_out`  out  32 (`word_t`)  IF/ID PC+4.
- `pc_out`  out  32 (`word_t`)  IF/ID PC of the instruction.
- `valid_out`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  stage is in HALT.

## Operation
- States: RUN, HOLD, HALT. Reset state RUN.
- Bubble = instr 32'h0 (sll $0, nop), npc 0, pc 0, valid 0.
- `imemREN` = 1 only in RUN and only while `nRST` is high; 0 in HOLD and HALT.
- Event priority per cycle: `halt_in` > `redirect` > normal flow.
- `halt_in`: IF/ID ← bubble, skid emptied, → HALT. HALT is exited only by reset.
- `redirect` (in RUN or HOLD): PC ← {redirect_pc[31:2],2'b00}, IF/ID ← bubble, skid emptied, → RUN. Overrides `stall_id` and any same-cycle `ihit`.
- RUN, `ihit`, `!stall_id`: IF/ID ← {imemload, PC+4, PC, valid 1}; PC ← PC+4.
- RUN, `ihit`, `stall_id`: IF/ID holds; skid ← {imemload, PC+4, PC}; PC ← PC+4; → HOLD.
- RUN, `!ihit`, `!stall_id`: IF/ID ← bubble; PC holds.
- RUN, `!ihit`, `stall_id`: everything holds.
- HOLD, `stall_id`: everything holds.
- HOLD, `!stall_id`: IF/ID ← skid contents, valid 1; skid emptied; → RUN. No icache request in this cycle.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (async, `nRST` low): PC = `PC_INIT`; IF/ID = bubble; skid empty; state RUN; `imemREN` 0, `imemaddr` = `PC_INIT`, `instr_out` 0, `npc_out` 0, `pc_out` 0, `valid_out` 0, `halted` 0.
- First cycle after reset release: `imemREN` 1, `imemaddr` = `PC_INIT`.
- Fetch latency: `ihit` in cycle N results in `instr_out` valid from cycle N+1.
- `imemaddr` and `imemREN` are combinational from registered PC/state only; no input-to-output combinational path.
- A redirect asserted in cycle N yields `imemaddr` = new PC in cycle N+1 and a bubble on IF/ID in N+1.
- `halted` is asserted from the cycle after `halt_in` and stays high.
- A reset asserted mid-HOLD or mid-HALT returns all state to reset values immediately.

## Structure
- `fetch_state_t` (RUN/HOLD/HALT) and the `NOP_INSTR` constant go in `cpu_types_pkg`.
- IF/ID outputs are grouped in a `fetch_if` interface with `fs` (stage) and `tb` modports, matching the pattern used by the other stage interfaces.
- One sub-module is natural: `fetch_skid`, a one-entry {instr, npc, pc} buffer with load/clear/full controls.

## Test plan
- Reset with `PC_INIT`=32'h0000_0040, `ihit` held 1 → after release `imemaddr` sequence 0x40, 0x44, 0x48; `pc_out` lags `imemaddr` by one cycle; `valid_out` 1.
- `ihit` 1 with `imemload`=32'h2001_0005 at PC 0x10 while `stall_id` 1 for 3 cycles → IF/ID unchanged, `imemREN` 0 during HOLD; on release `instr_out`=32'h2001_0005, `pc_out`=0x10, `npc_out`=0x14.
- Same-cycle `redirect` (redirect_pc=32'h0000_0203) with `ihit` and `stall_id` → next cycle `imemaddr`=0x200, `valid_out` 0, skid empty.
- `ihit` 0 for 2 cycles, `stall_id` 0 → two bubbles (`instr_out` 0, `valid_out` 0), `imemaddr` constant.
- `halt_in` pulsed for one cycle during HOLD → `halted` 1 next cycle, `imemREN` 0, bubble on IF/ID; later `redirect` ignored; `nRST` low clears `halted`.
- PC at 32'hFFFF_FFFC with `ihit` → `npc_out` 0, next `imemaddr` 0.
